uart_tx_queue_arbiter: RTL and testbench



---
 rtl/uart_tx_queue_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_queue_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue_arbiter.sv
// uart_tx_queue_arbiter: round-robin arbiter that packs requester bytes into the UART TX ring
// and advances the ring tail through the MMIO command port.
module uart_tx_queue_arbiter #(
   parameter int          NUM_REQ   = 2,
   parameter logic [31:0] HEAD_ADDR = 32'h0000_0100,
   parameter logic [31:0] TAIL_ADDR = 32'h0000_0104
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 mmio_cmd_start,
   output logic                 mmio_cmd_write,
   input  logic                 mmio_cmd_ready,
   output logic [31:0]          mmio_addr,
   output logic [31:0]          mmio_wdata,
   input  logic [31:0]          mmio_rdata,
   input  logic                 mmio_rdata_valid,
   output logic                 busy,
   output logic                 full
);
   localparam int GW = $clog2(NUM_REQ);
   typedef enum logic [3:0] {
      INIT_TAIL, WAIT_TAIL, INIT_WORD, WAIT_WORD, IDLE, RD_HEAD, WAIT_HEAD, WR_WORD, WR_TAIL
   } state_t;
   state_t        state_q, state_d;
   logic [GW-1:0] rr_q, rr_d, gnt_q, gnt_d, pick;
   logic [GW:0]   idx;
   logic          found, issue;
   logic [7:0]    tail_q, tail_d, byte_q, byte_d;
   logic [31:0]   shadow_q, shadow_d, merged;
   logic          full_q, full_d, start_q, start_d, write_q, write_d;
   logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
   assign issue          = start_q && mmio_cmd_ready;
   assign mmio_cmd_start = start_q;
   assign mmio_cmd_write = write_q;
   assign mmio_addr      = addr_q;
   assign mmio_wdata     = wdata_q;
   assign busy           = state_q != IDLE;
   assign full           = full_q;
   // Scan downwards so the last hit is the first valid index at or after rr_q.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_q} + (GW+1)'(k);
         idx = (idx >= (GW+1)'(NUM_REQ)) ? idx - (GW+1)'(NUM_REQ) : idx;
         if (req_valid[idx[GW-1:0]]) begin
            pick  = idx[GW-1:0];
            found = 1'b1;
         end
      end
   end
   always_comb begin
      merged = (tail_q[1:0] == 2'd0) ? 32'd0 : shadow_q;
      merged[8*tail_q[1:0] +: 8] = byte_q;
   end
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      gnt_d     = gnt_q;
      tail_d    = tail_q;
      byte_d    = byte_q;
      shadow_d  = shadow_q;
      full_d    = full_q;
      req_ready = '0;
      case (state_q)
         INIT_TAIL: state_d = issue ? WAIT_TAIL : INIT_TAIL;
         WAIT_TAIL: if (mmio_rdata_valid) begin
            tail_d  = mmio_rdata[7:0];
            state_d = (mmio_rdata[1:0] != 2'd0) ? INIT_WORD : IDLE;
         end
         INIT_WORD: state_d = issue ? WAIT_WORD : INIT_WORD;
         WAIT_WORD: if (mmio_rdata_valid) begin
            shadow_d = mmio_rdata;
            state_d  = IDLE;
         end
         IDLE: if (found) begin
            gnt_d   = pick;
            byte_d  = req_data[8*pick +: 8];
            state_d = RD_HEAD;
         end
         RD_HEAD: state_d = issue ? WAIT_HEAD : RD_HEAD;
         WAIT_HEAD: if (mmio_rdata_valid) begin
            full_d  = (tail_q + 8'd1) == mmio_rdata[7:0];
            state_d = full_d ? RD_HEAD : WR_WORD;
         end
         WR_WORD: if (issue) begin
            shadow_d = merged;
            state_d  = WR_TAIL;
         end
         WR_TAIL: if (issue) begin
            tail_d    = tail_q + 8'd1;
            req_ready = NUM_REQ'(1) << gnt_q;
            rr_d      = (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            state_d   = IDLE;
         end
         default: state_d = INIT_TAIL;
      endcase
   end
   // Command outputs are registered from the next state so they line up with it.
   always_comb begin
      start_d = 1'b1;
      write_d = 1'b0;
      addr_d  = 32'd0;
      wdata_d = 32'd0;
      case (state_d)
         INIT_TAIL: addr_d = TAIL_ADDR;
         INIT_WORD: addr_d = {24'd0, tail_d[7:2], 2'b00};
         RD_HEAD:   addr_d = HEAD_ADDR;
         WR_WORD: begin
            write_d = 1'b1;
            addr_d  = {24'd0, tail_d[7:2], 2'b00};
            wdata_d = merged;
         end
         WR_TAIL: begin
            write_d = 1'b1;
            addr_d  = TAIL_ADDR;
            wdata_d = {24'd0, tail_d + 8'd1};
         end
         default: start_d = 1'b0;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= INIT_TAIL;
         rr_q     <= '0;
         gnt_q    <= '0;
         tail_q   <= '0;
         byte_q   <= '0;
         shadow_q <= '0;
         full_q   <= 1'b0;
         start_q  <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         gnt_q    <= gnt_d;
         tail_q   <= tail_d;
         byte_q   <= byte_d;
         shadow_q <= shadow_d;
         full_q   <= full_d;
         start_q  <= start_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_queue_arbiter.sv
// tb_uart_tx_queue_arbiter: directed scenarios against a small MMIO ring slave model.
module tb_uart_tx_queue_arbiter;
   localparam logic [31:0] HEAD_ADDR = 32'h0000_0100;
   localparam logic [31:0] TAIL_ADDR = 32'h0000_0104;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [15:0] req_data = '0;
   logic [1:0]  req_ready;
   logic        cmd_start, cmd_write, busy, full, rvalid;
   logic        cmd_ready = 1'b1;
   logic [31:0] addr, wdata, rdata;
   logic [7:0]  head_reg = '0;
   logic [7:0]  init_tail = '0;
   logic [7:0]  tail_reg;
   logic [31:0] mem [64];
   logic [31:0] init_mem [64];
   logic [31:0] last_rd_addr;
   int          gnt_log [16];
   int          word_wr_cnt, tail_wr_cnt, rd_cnt, pulse_cnt;
   int          errors = 0;
   int          checks = 0;
   uart_tx_queue_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .mmio_cmd_start(cmd_start), .mmio_cmd_write(cmd_write), .mmio_cmd_ready(cmd_ready),
      .mmio_addr(addr), .mmio_wdata(wdata), .mmio_rdata(rdata), .mmio_rdata_valid(rvalid),
      .busy(busy), .full(full)
   );
   always #5 clk = ~clk;
   // MMIO ring slave: registered read data, tail register, 64-word buffer, commit logger.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tail_reg <= init_tail;
         for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
         rvalid <= 1'b0;
         rdata <= '0;
         last_rd_addr <= '0;
         word_wr_cnt <= 0;
         tail_wr_cnt <= 0;
         rd_cnt <= 0;
         pulse_cnt <= 0;
      end else begin
         rvalid <= 1'b0;
         if (cmd_start && cmd_ready) begin
            if (cmd_write) begin
               if (addr == TAIL_ADDR) begin
                  tail_reg <= wdata[7:0];
                  tail_wr_cnt <= tail_wr_cnt + 1;
               end else begin
                  mem[addr[7:2]] <= wdata;
                  word_wr_cnt <= word_wr_cnt + 1;
               end
            end else begin
               rd_cnt <= rd_cnt + 1;
               last_rd_addr <= addr;
               rdata <= (addr == HEAD_ADDR) ? {24'd0, head_reg} :
                        (addr == TAIL_ADDR) ? {24'd0, tail_reg} : mem[addr[7:2]];
               rvalid <= 1'b1;
            end
         end
         if (|req_ready) begin
            gnt_log[pulse_cnt % 16] <= req_ready[1] ? 1 : 0;
            pulse_cnt <= pulse_cnt + 1;
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   task automatic do_reset(input logic [7:0] t);
      req_valid = '0;
      cmd_ready = 1'b1;
      init_tail = t;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask
   task automatic wait_pulses(input int n, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (pulse_cnt >= n) begin
            ok = 1'b1;
            break;
         end
      end
      req_valid = '0;
   endtask
   task automatic test_reset;
      for (int i = 0; i < 64; i++) init_mem[i] = '0;
      head_reg = 8'd0;
      init_tail = 8'd0;
      cmd_ready = 1'b1;
      req_valid = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (cmd_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", cmd_start); end
      checks++; if (cmd_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", cmd_write); end
      checks++; if (addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
      checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_idle_busy: got %b want 0", busy); end
      checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL init_read_count: got %0d want 1", rd_cnt); end
      checks++; if (last_rd_addr !== TAIL_ADDR) begin errors++; $display("FAIL init_read_addr: got %h want %h", last_rd_addr, TAIL_ADDR); end
   endtask
   task automatic test_single;
      bit ok;
      req_data = 16'h0041;
      req_valid = 2'b01;
      wait_pulses(1, 30, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout: got no req_ready pulse"); end
      checks++; if (mem[0] !== 32'h0000_0041) begin errors++; $display("FAIL single_word0: got %h want 00000041", mem[0]); end
      checks++; if (tail_reg !== 8'd1) begin errors++; $display("FAIL single_tail: got %0d want 1", tail_reg); end
      checks++; if (gnt_log[0] !== 0) begin errors++; $display("FAIL single_grant: got %0d want 0", gnt_log[0]); end
      checks++; if (word_wr_cnt !== 1 || tail_wr_cnt !== 1) begin errors++; $display("FAIL single_writes: got word=%0d tail=%0d want 1/1", word_wr_cnt, tail_wr_cnt); end
      checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", pulse_cnt); end
      checks++; if (busy !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL single_after: got busy=%b ready=%b want 0/00", busy, req_ready); end
   endtask
   task automatic test_alternate;
      bit ok;
      for (int i = 0; i < 64; i++) init_mem[i] = '0;
      head_reg = 8'd0;
      do_reset(8'd0);
      req_data = 16'hB0A0;
      req_valid = 2'b11;
      wait_pulses(4, 80, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL alt_timeout: got %0d pulses want 4", pulse_cnt); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (gnt_log[i] !== i % 2) begin errors++; $display("FAIL alt_grant%0d: got %0d want %0d", i, gnt_log[i], i % 2); end
      end
      checks++; if (mem[0] !== 32'hB0A0_B0A0) begin errors++; $display("FAIL alt_word0: got %h want b0a0b0a0", mem[0]); end
      checks++; if (tail_reg !== 8'd4) begin errors++; $display("FAIL alt_tail: got %0d want 4", tail_reg); end
   endtask
   task automatic test_full_wrap;
      bit ok;
      for (int i = 0; i < 64; i++) init_mem[i] = '0;
      init_mem[63] = 32'h0011_2233;
      head_reg = 8'd0;
      do_reset(8'd255);
      req_data = 16'h5A00;
      req_valid = 2'b10;
      repeat (25) @(negedge clk);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
      checks++; if (word_wr_cnt !== 0 || tail_wr_cnt !== 0) begin errors++; $display("FAIL full_no_writes: got word=%0d tail=%0d want 0/0", word_wr_cnt, tail_wr_cnt); end
      checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL full_no_ready: got %0d pulses want 0", pulse_cnt); end
      checks++; if (rd_cnt < 4) begin errors++; $display("FAIL full_polling: got %0d reads want at least 4", rd_cnt); end
      head_reg = 8'd10;
      wait_pulses(1, 30, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_timeout: got no req_ready pulse"); end
      checks++; if (mem[63] !== 32'h5A11_2233) begin errors++; $display("FAIL wrap_word63: got %h want 5a112233", mem[63]); end
      checks++; if (tail_reg !== 8'd0) begin errors++; $display("FAIL wrap_tail: got %0d want 0", tail_reg); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full: got %b want 0", full); end
      checks++; if (gnt_log[0] !== 1) begin errors++; $display("FAIL wrap_grant: got %0d want 1", gnt_log[0]); end
   endtask
   task automatic test_init_word;
      bit ok;
      for (int i = 0; i < 64; i++) init_mem[i] = '0;
      init_mem[1] = 32'h0000_4443;
      head_reg = 8'd0;
      do_reset(8'h06);
      req_data = 16'h0045;
      req_valid = 2'b01;
      wait_pulses(1, 40, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL initw_timeout: got no req_ready pulse"); end
      checks++; if (mem[1] !== 32'h0045_4443) begin errors++; $display("FAIL initw_word1: got %h want 00454443", mem[1]); end
      checks++; if (tail_reg !== 8'd7) begin errors++; $display("FAIL initw_tail: got %0d want 7", tail_reg); end
      checks++; if (rd_cnt !== 3) begin errors++; $display("FAIL initw_reads: got %0d want 3", rd_cnt); end
      checks++; if (word_wr_cnt !== 1) begin errors++; $display("FAIL initw_writes: got %0d want 1", word_wr_cnt); end
   endtask
   task automatic test_stall;
      bit ok;
      bit seen;
      for (int i = 0; i < 64; i++) init_mem[i] = '0;
      head_reg = 8'd0;
      do_reset(8'd0);
      req_data = 16'h0077;
      req_valid = 2'b01;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_start && cmd_write && addr != TAIL_ADDR) begin
            seen = 1'b1;
            break;
         end
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stall_reach_wr_word: got no word write command"); end
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (cmd_start !== 1'b1 || cmd_write !== 1'b1 || addr !== 32'd0 || wdata !== 32'h77 || word_wr_cnt !== 0 || req_ready !== 2'b00)
         begin
            errors++;
            $display("FAIL stall_hold%0d: got start=%b write=%b addr=%h wdata=%h writes=%0d ready=%b want 1/1/0/77/0/00",
                     i, cmd_start, cmd_write, addr, wdata, word_wr_cnt, req_ready);
         end
      end
      cmd_ready = 1'b1;
      wait_pulses(1, 20, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout: got no req_ready pulse"); end
      checks++; if (word_wr_cnt !== 1 || tail_wr_cnt !== 1) begin errors++; $display("FAIL stall_writes: got word=%0d tail=%0d want 1/1", word_wr_cnt, tail_wr_cnt); end
      checks++; if (mem[0] !== 32'h0000_0077) begin errors++; $display("FAIL stall_word0: got %h want 00000077", mem[0]); end
      checks++; if (tail_reg !== 8'd1) begin errors++; $display("FAIL stall_tail: got %0d want 1", tail_reg); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_full_wrap();
      test_init_word();
      test_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
